song_sequencer: RTL and testbench
=================================

Name: song_sequencer

Overview:
- Upstream control stage for the birthday-song player. Steps through a fixed internal 25-entry note table (Happy Birthday in F major).
- Drives a one-hot enable bus. Each bit gates one per-pitch square-wave tone generator, all sharing the 100 MHz clk.
- Inserts a silent gap between notes. This drops every enable low, so each tone generator's divider counter restarts and repeated notes are audibly separated.

Parameters:
- TICK_DIV, 100_000: clk cycles per timing tick (1 ms at 100 MHz).
- UNIT_TICKS, 125: ticks per duration unit (eighth note).
- GAP_TICKS, 20: silent ticks at the end of every note. Must satisfy 1 <= GAP_TICKS < UNIT_TICKS.

Ports:
- clk  input  1  system clock, 100 MHz.
- rst  input  1  synchronous reset, active-high.
- start  input  1  begin playback. Level sampled in IDLE only.
- stop  input  1  abort playback. Synchronous, highest priority after rst.
- note_en  output  8  one-hot pitch enable. Bit order: 0=C5, 1=D5, 2=E5, 3=F5, 4=G5 (784 Hz), 5=A5, 6=Bb5, 7=C6.
- step  output  5  index of the current table entry, 0..24.
- busy  output  1  high while in NOTE or GAP.
- done  output  1  one-cycle pulse at song completion.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, note_en=0, step=0, busy=0, done=0, tick prescaler=0, tick counter=0.
- Note table (pitch code, units), in order:
  - 0/1, 0/1, 1/2, 0/2, 3/2, 2/4
  - 0/1, 0/1, 1/2, 0/2, 4/2, 3/4
  - 0/1, 0/1, 7/2, 5/2, 3/2, 2/2, 1/4
  - 6/1, 6/1, 5/2, 3/2, 4/2, 3/4
  - 50 units total.
  - Table is ROM (case statement). Pitch is 3 bits, units are 3 bits.
- FSM states: IDLE, NOTE, GAP.
  - IDLE -> NOTE: on start=1 at edge t. At t+1: step=0, note_en=onehot(pitch[0]), busy=1, prescaler and tick counter cleared.
  - NOTE: note_en=onehot(pitch[step]). Lasts exactly (units[step]*UNIT_TICKS - GAP_TICKS)*TICK_DIV cycles, then -> GAP.
  - GAP: note_en=0, busy=1. Lasts exactly GAP_TICKS*TICK_DIV cycles.
    - If step<24: -> NOTE with step+1, counters cleared.
    - If step==24: -> IDLE with step=0, busy=0, done=1 for that one cycle.
- Whole song: exactly 50*UNIT_TICKS*TICK_DIV cycles, from the first cycle busy=1 to the cycle done=1.
- Prescaler: counts 0..TICK_DIV-1 and emits an internal tick on wrap. The tick counter counts ticks within the current phase. Both clear on every phase change, so timing is cycle-exact.
- note_en is registered; at most one bit is ever set.
- start while busy: ignored. start held high in IDLE after done: restarts on the next cycle.
- stop=1 in any state: next cycle state=IDLE, note_en=0, step=0, busy=0, done=0 (no done pulse). stop and start in the same IDLE cycle: stop wins.
- rst mid-note: same result as stop, and all counters are cleared.

Optional Feature:
- Macro: SONG_LOOP_EN.
- Defined: on completion of the step-24 GAP, the FSM goes to NOTE with step=0 instead of IDLE. done still pulses for one cycle on that wrap and busy stays 1. Playback continues until stop or rst.
- Undefined: single playback, returning to IDLE as described above.

Test Plan (all scenarios use TICK_DIV=4, UNIT_TICKS=5, GAP_TICKS=1):
- Reset: rst=1 for 3 cycles with start=1 -> note_en=0, step=0, busy=0, done=0 throughout and on the first cycle after release, no playback starts until a start is sampled in IDLE.
- First note: start pulse at cycle t -> note_en=8'h01 for cycles t+1..t+16, 8'h00 for t+17..t+20, 8'h01 again at t+21 with step=1.
- Long note and completion: measure step 5 (E5, 4 units) -> note_en=8'h04 for exactly 76 cycles. done=1 exactly 1000 cycles after the first busy cycle, then busy=0 and step=0.
- Abort: assert stop at step 7 mid-NOTE -> next cycle note_en=0, busy=0, no done pulse. A subsequent start replays from step 0 with pitch C5.
- Protocol: start pulsed repeatedly while busy -> timing unchanged and song completes at 1000 cycles. stop and start together in IDLE -> stays IDLE.
- SONG_LOOP_EN defined: run 2100 cycles -> done pulses at 1000 and 2000, busy never drops, step wraps 24->0 with note_en=8'h01.

Source files
------------

// File: rtl/song_sequencer.sv
// Birthday-song sequencer: walks a 25-entry note ROM, driving a one-hot pitch enable with a
// silent gap after each note. Define SONG_LOOP_EN to replay continuously instead of stopping.
module song_sequencer #(
    parameter int unsigned TICK_DIV   = 100_000,
    parameter int unsigned UNIT_TICKS = 125,
    parameter int unsigned GAP_TICKS  = 20
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_stop,
    output logic [7:0] o_note_en,
    output logic [4:0] o_step,
    output logic       o_busy,
    output logic       o_done
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned TW = $clog2(8 * UNIT_TICKS);
    localparam logic [4:0] LastStep = 5'd24;

    typedef enum logic [1:0] {StIdle, StNote, StGap} state_t;

    function automatic logic [2:0] pitch_rom(input logic [4:0] idx);
        case (idx)
            5'd2, 5'd8:                            pitch_rom = 3'd1;
            5'd4, 5'd11, 5'd16, 5'd22, 5'd24:      pitch_rom = 3'd3;
            5'd5, 5'd17:                           pitch_rom = 3'd2;
            5'd10, 5'd23:                          pitch_rom = 3'd4;
            5'd14:                                 pitch_rom = 3'd7;
            5'd15, 5'd21:                          pitch_rom = 3'd5;
            5'd18:                                 pitch_rom = 3'd1;
            5'd19, 5'd20:                          pitch_rom = 3'd6;
            default:                               pitch_rom = 3'd0;
        endcase
    endfunction

    function automatic logic [2:0] units_rom(input logic [4:0] idx);
        case (idx)
            5'd0, 5'd1, 5'd6, 5'd7, 5'd12, 5'd13, 5'd19, 5'd20: units_rom = 3'd1;
            5'd5, 5'd11, 5'd18, 5'd24:                           units_rom = 3'd4;
            default:                                             units_rom = 3'd2;
        endcase
    endfunction

    state_t      r_state;
    logic [PW-1:0] r_presc;
    logic [TW-1:0] r_tick;
    logic [4:0]  r_step;
    logic [7:0]  r_note_en;
    logic        r_busy;
    logic        r_done;

    state_t      w_state_nxt;
    logic [4:0]  w_step_nxt;
    logic [7:0]  w_note_en_nxt;
    logic        w_busy_nxt;
    logic        w_done_nxt;
    logic        w_clear;
    logic        w_tick;
    logic        w_phase_end;
    logic [2:0]  w_units;
    logic [2:0]  w_nxt_pitch;
    logic [TW-1:0] w_note_last;
    logic [TW-1:0] w_gap_last;
    logic [TW-1:0] w_last;

    assign w_tick      = (r_presc == PW'(TICK_DIV - 1));
    assign w_units     = units_rom(r_step);
    // Last tick index of the sounding part; the gap is carved out of the note's full length.
    assign w_note_last = TW'(32'(w_units) * UNIT_TICKS - GAP_TICKS - 1);
    assign w_gap_last  = TW'(GAP_TICKS - 1);
    assign w_last      = (r_state == StNote) ? w_note_last : w_gap_last;
    assign w_phase_end = w_tick && (r_tick == w_last);

    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step;
        w_done_nxt  = 1'b0;
        w_clear     = 1'b0;
        if (i_stop) begin
            w_state_nxt = StIdle;
            w_step_nxt  = '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_start) begin
                        w_state_nxt = StNote;
                        w_step_nxt  = '0;
                        w_clear     = 1'b1;
                    end
                end
                StNote: begin
                    if (w_phase_end) begin
                        w_state_nxt = StGap;
                        w_clear     = 1'b1;
                    end
                end
                StGap: begin
                    if (w_phase_end) begin
                        w_clear = 1'b1;
                        if (r_step == LastStep) begin
                            w_done_nxt = 1'b1;
                            w_step_nxt = '0;
`ifdef SONG_LOOP_EN
                            w_state_nxt = StNote;
`else
                            w_state_nxt = StIdle;
`endif
                        end else begin
                            w_step_nxt  = r_step + 5'd1;
                            w_state_nxt = StNote;
                        end
                    end
                end
                default: w_state_nxt = StIdle;
            endcase
        end
        // Counters stay parked at zero whenever idle.
        if (w_state_nxt == StIdle) begin
            w_clear = 1'b1;
        end
        w_nxt_pitch   = pitch_rom(w_step_nxt);
        w_note_en_nxt = (w_state_nxt == StNote) ? (8'd1 << w_nxt_pitch) : 8'd0;
        w_busy_nxt    = (w_state_nxt != StIdle);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= StIdle;
            r_presc   <= '0;
            r_tick    <= '0;
            r_step    <= '0;
            r_note_en <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_step    <= w_step_nxt;
            r_note_en <= w_note_en_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            if (w_clear) begin
                r_presc <= '0;
                r_tick  <= '0;
            end else if (w_tick) begin
                r_presc <= '0;
                r_tick  <= r_tick + TW'(1);
            end else begin
                r_presc <= r_presc + PW'(1);
            end
        end
    end

    assign o_note_en = r_note_en;
    assign o_step    = r_step;
    assign o_busy    = r_busy;
    assign o_done    = r_done;

endmodule

// File: tb/tb_song_sequencer.sv
// Scoreboard bench for song_sequencer: an elapsed-time song model predicts every output change.
module tb_song_sequencer;

    localparam int unsigned TD = 4;
    localparam int unsigned UT = 5;
    localparam int unsigned GT = 1;
    localparam int SONG = 50 * UT * TD;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [7:0] note_en;
    logic [4:0] step;
    logic       busy;
    logic       done;

    song_sequencer #(
        .TICK_DIV  (TD),
        .UNIT_TICKS(UT),
        .GAP_TICKS (GT)
    ) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_start  (start),
        .i_stop   (stop),
        .o_note_en(note_en),
        .o_step   (step),
        .o_busy   (busy),
        .o_done   (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int pitch_tab [25] = '{0, 0, 1, 0, 3, 2, 0, 0, 1, 0, 4, 3, 0, 0, 7, 5, 3, 2, 1,
                           6, 6, 5, 3, 4, 3};
    int units_tab [25] = '{1, 1, 2, 2, 2, 4, 1, 1, 2, 2, 2, 4, 1, 1, 2, 2, 2, 2, 4,
                           1, 1, 2, 2, 2, 4};

    typedef struct {
        int          cyc;
        logic [14:0] tup;
    } ev_t;
    ev_t exp_q[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Position within the song from elapsed cycles since the first busy cycle.
    function automatic void song_pos(input int e, output logic [4:0] s, output logic [7:0] en);
        int acc;
        int len;
        acc = 0;
        s   = '0;
        en  = '0;
        for (int i = 0; i < 25; i++) begin
            len = units_tab[i] * UT * TD;
            if (e >= acc && e < acc + len) begin
                s  = 5'(i);
                en = (e - acc < (units_tab[i] * UT - GT) * TD) ? 8'(1 << pitch_tab[i]) : 8'h00;
            end
            acc += len;
        end
    endfunction

    // Reference model: reacts to sampled inputs, queues every expected output change.
    initial begin
        logic        m_play;
        logic        m_done;
        int          m_e;
        logic [4:0]  s;
        logic [7:0]  en;
        logic [14:0] tup;
        logic [14:0] prev;
        m_play = 1'b0;
        m_done = 1'b0;
        m_e    = 0;
        prev   = '0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            if (rst || stop) begin
                m_play = 1'b0;
                m_done = 1'b0;
            end else if (!m_play) begin
                m_done = 1'b0;
                if (start) begin
                    m_play = 1'b1;
                    m_e    = 0;
                end
            end else begin
                m_e++;
                m_done = 1'b0;
                if (m_e == SONG) begin
                    m_done = 1'b1;
                    m_e    = 0;
`ifndef SONG_LOOP_EN
                    m_play = 1'b0;
`endif
                end
            end
            if (m_play) song_pos(m_e, s, en);
            else begin
                s  = '0;
                en = '0;
            end
            tup = {en, s, m_play, m_done};
            if (tup != prev) begin
                exp_q.push_back('{cyc: cyc, tup: tup});
                prev = tup;
            end
        end
    end

    // Monitor: every change of the DUT outputs must match the next queued expectation.
    initial begin
        logic [14:0] d_prev;
        logic [14:0] d_now;
        ev_t         ev;
        d_prev = '0;
        forever begin
            @(negedge clk);
            if (cyc > 0) begin
                check("onehot", 32'($countones(note_en) <= 1), 32'd1);
                d_now = {note_en, step, busy, done};
                if (d_now !== d_prev) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_change: got %0h at cycle %0d, expected none",
                                 d_now, cyc);
                    end else begin
                        ev = exp_q.pop_front();
                        if (ev.tup !== d_now || ev.cyc != cyc) begin
                            n_fail++;
                            $display("FAIL output_event: got %0h at cycle %0d, expected %0h at cycle %0d",
                                     d_now, cyc, ev.tup, ev.cyc);
                        end
                    end
                    d_prev = d_now;
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
    endtask

    initial begin
        int first;
        int n;
        int len;
        int dones;
        logic dropped;

        // Reset held with start high
        start = 1'b1;
        repeat (3) begin
            tick();
            check("reset_outputs", 32'({note_en, step, busy, done}), 32'd0);
        end
        rst   = 1'b0;
        start = 1'b0;
        tick();
        check("after_reset_idle", 32'({note_en, step, busy, done}), 32'd0);
        repeat (3) tick();
        check("idle_without_start", 32'(busy), 32'd0);

        // First note and gap timing
        pulse_start();
        first = cyc;
        check("first_note", 32'({note_en, step, busy}), 32'({8'h01, 5'd0, 1'b1}));
        repeat (15) tick();
        check("first_note_end", 32'(note_en), 32'h01);
        tick();
        check("first_gap", 32'({note_en, busy}), 32'({8'h00, 1'b1}));
        repeat (3) tick();
        check("first_gap_end", 32'(note_en), 32'h00);
        tick();
        check("second_note", 32'({note_en, step}), 32'({8'h01, 5'd1}));

        // Long note length, then completion latency
        n = 0;
        while (!(step == 5'd5 && note_en != 8'h00) && n < 2000) begin
            tick();
            n++;
        end
        check("reach_step5", 32'(step), 32'd5);
        len = 0;
        while (note_en == 8'h04 && step == 5'd5 && len < 200) begin
            len++;
            tick();
        end
        check("step5_len", 32'(len), 32'd76);
        n = 0;
        while (done !== 1'b1 && n < 2000) begin
            tick();
            n++;
        end
        check("done_latency", 32'(cyc - first), 32'(SONG));
`ifdef SONG_LOOP_EN
        check("done_wrap", 32'({busy, step, note_en}), 32'({1'b1, 5'd0, 8'h01}));
`else
        check("done_idle", 32'({busy, step}), 32'd0);
`endif
        tick();
        check("done_one_cycle", 32'(done), 32'd0);

        // Abort mid-note at step 7, then replay from the top
        n = 0;
        if (!busy) pulse_start();
        while (!(step == 5'd7 && note_en != 8'h00) && n < 2000) begin
            tick();
            n++;
        end
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("abort", 32'({note_en, busy, done, step}), 32'd0);
        tick();
        check("abort_no_done", 32'(done), 32'd0);
        pulse_start();
        check("replay", 32'({note_en, step, busy}), 32'({8'h01, 5'd0, 1'b1}));
        pulse_stop();

        // start hammered while busy leaves timing unchanged
        pulse_start();
        first = cyc;
        n = 0;
        while (done !== 1'b1 && n < 2000) begin
            start = ($urandom_range(0, 3) == 0);
            tick();
            n++;
        end
        start = 1'b0;
        check("busy_start_latency", 32'(cyc - first), 32'(SONG));
        pulse_stop();

        // stop beats start in IDLE
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        tick();
        check("stop_wins", 32'({busy, note_en}), 32'd0);

`ifdef SONG_LOOP_EN
        pulse_start();
        first   = cyc;
        dones   = 0;
        dropped = 1'b0;
        for (int i = 1; i <= 2100; i++) begin
            tick();
            if (!busy) dropped = 1'b1;
            if (done) begin
                dones++;
                check("loop_done_cyc", 32'(cyc - first), 32'(dones * SONG));
                check("loop_wrap", 32'({step, note_en}), 32'({5'd0, 8'h01}));
            end
        end
        check("loop_dones", 32'(dones), 32'd2);
        check("loop_busy_held", 32'(dropped), 32'd0);
        pulse_stop();
`endif

        // Random episodes: spurious starts, aborted by stop or rst at a random point
        for (int ep = 0; ep < 8; ep++) begin
            pulse_start();
            n = $urandom_range(1, 1100);
            repeat (n) begin
                start = ($urandom_range(0, 7) == 0);
                tick();
            end
            start = 1'b0;
            if ($urandom_range(0, 1) == 0) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                tick();
            end else begin
                pulse_stop();
            end
            check("episode_idle", 32'({busy, note_en, step}), 32'd0);
        end

        repeat (4) tick();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
